instr_encoder: RTL and testbench

Program-loader-side encoder that produces machine words for the single-cycle core.
- Accepts symbolic instruction requests (mnemonic select plus register/immediate fields) over a valid/ready stream.
- Emits 32-bit words in exactly the field layout the core's decoder accepts.
- Writes each word into instruction memory at consecutive word addresses.
- Sits between the bench/boot controller and the instruction-memory write port.

---
 rtl/instr_encoder_pkg.sv | 40 ++++
 rtl/instr_field_pack.sv | 66 ++++++
 rtl/instr_encoder.sv | 127 ++++++++++++
 tb/tb_instr_encoder.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_encoder_pkg.sv
// Shared encodings for the instruction encoder: request selects, opcode/cmd fields, FSM states.
// Pure definitions, no logic.
// Imported by instr_field_pack and instr_encoder.
package instr_encoder_pkg;

  // Request mnemonic selects (9-15 are illegal)
  localparam logic [3:0] SEL_ADD = 4'd0;
  localparam logic [3:0] SEL_SUB = 4'd1;
  localparam logic [3:0] SEL_AND = 4'd2;
  localparam logic [3:0] SEL_ORR = 4'd3;
  localparam logic [3:0] SEL_CMP = 4'd4;
  localparam logic [3:0] SEL_LSL = 4'd5;
  localparam logic [3:0] SEL_LSR = 4'd6;
  localparam logic [3:0] SEL_LDR = 4'd7;
  localparam logic [3:0] SEL_STR = 4'd8;

  // Instruction op field
  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;

  // cmd field values understood by the core's decoder
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_ORR = 4'b1100;
  localparam logic [3:0] CMD_CMP = 4'b1010;
  localparam logic [3:0] CMD_LSL = 4'b0011;
  localparam logic [3:0] CMD_LSR = 4'b0001;

  // Shift type codes placed in Src2[6:5]
  localparam logic [1:0] SH_LSL = 2'b00;
  localparam logic [1:0] SH_LSR = 2'b01;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/instr_field_pack.sv
// Maps a symbolic request (select + register/immediate fields) to a 32-bit machine word.
// Latency: purely combinational.
// No flow control; illegal_o flags selects 9-15 (word_o is don't-care then).
module instr_field_pack
  import instr_encoder_pkg::*;
(
  input  logic [3:0]  sel_i,
  input  logic [3:0]  cond_i,
  input  logic [3:0]  rn_i,
  input  logic [3:0]  rd_i,
  input  logic [3:0]  rm_i,
  input  logic [11:0] imm_i,
  output logic [31:0] word_o,
  output logic        illegal_o
);

  logic [1:0]  op;
  logic [5:0]  funct;
  logic [3:0]  rn;
  logic [3:0]  rd;
  logic [11:0] src2;

  // Select per-mnemonic field values; defaults describe a register-operand DP op
  always_comb begin
    op        = OP_DP;
    funct     = 6'b000000;
    rn        = rn_i;
    rd        = rd_i;
    src2      = {8'h00, rm_i};
    illegal_o = 1'b0;
    case (sel_i)
      SEL_ADD: funct = {1'b0, CMD_ADD, 1'b0};
      SEL_SUB: funct = {1'b0, CMD_SUB, 1'b0};
      SEL_AND: funct = {1'b0, CMD_AND, 1'b0};
      SEL_ORR: funct = {1'b0, CMD_ORR, 1'b0};
      SEL_CMP: begin
        // Compare only sets flags, so Rd carries no meaning
        funct = {1'b0, CMD_CMP, 1'b1};
        rd    = 4'h0;
      end
      SEL_LSL: begin
        funct = {1'b1, CMD_LSL, 1'b0};
        rn    = 4'h0;
        src2  = {imm_i[4:0], SH_LSL, 1'b0, rm_i};
      end
      SEL_LSR: begin
        funct = {1'b1, CMD_LSR, 1'b0};
        rn    = 4'h0;
        src2  = {imm_i[4:0], SH_LSR, 1'b0, rm_i};
      end
      SEL_LDR: begin
        op    = OP_MEM;
        funct = 6'b011001;
        src2  = imm_i;
      end
      SEL_STR: begin
        op    = OP_MEM;
        funct = 6'b011000;
        src2  = imm_i;
      end
      default: illegal_o = 1'b1;
    endcase
    word_o = {cond_i, op, funct, rn, rd, src2};
  end

endmodule

// File: rtl/instr_encoder.sv
// Accepts symbolic instruction requests and writes encoded words to consecutive imem addresses.
// Latency: imem write strobe one cycle after request acceptance; 1 request/cycle throughput.
// req_ready only in LOAD while word_count < IMEM_DEPTH; illegal selects are consumed without a write.
module instr_encoder
  import instr_encoder_pkg::*;
#(
  parameter int          IMEM_DEPTH = 64,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [3:0]  req_sel,
  input  logic [3:0]  req_cond,
  input  logic [3:0]  req_rn,
  input  logic [3:0]  req_rd,
  input  logic [3:0]  req_rm,
  input  logic [11:0] req_imm,
  input  logic        req_last,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        ovf,
  output logic [6:0]  word_count
);

  localparam logic [6:0] DEPTH_C = 7'(IMEM_DEPTH);

  state_e      state_q, state_d;
  logic [6:0]  word_count_q;
  logic [31:0] ptr_q;
  logic        err_q, ovf_q;
  logic        we_q;
  logic [31:0] addr_q, wdata_q;

  logic [31:0] enc_word;
  logic        enc_illegal;
  logic        accept;
  logic        session_start;
  logic        mem_full;

  instr_field_pack u_pack (
    .sel_i     (req_sel),
    .cond_i    (req_cond),
    .rn_i      (req_rn),
    .rd_i      (req_rd),
    .rm_i      (req_rm),
    .imm_i     (req_imm),
    .word_o    (enc_word),
    .illegal_o (enc_illegal)
  );

  // word_count counts words already committed, so ready drops right after the last slot is taken
  assign req_ready     = (state_q == ST_LOAD) && (word_count_q < DEPTH_C);
  assign accept        = req_valid && req_ready;
  assign session_start = start && (state_q != ST_LOAD);
  assign mem_full      = (state_q == ST_LOAD) && (word_count_q >= DEPTH_C);

  // Next-state logic: accepted last request wins over the memory-full stop
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start) state_d = ST_LOAD;
      ST_LOAD: begin
        if (accept && req_last) state_d = ST_DONE;
        else if (mem_full)      state_d = ST_DONE;
      end
      ST_DONE: if (start) state_d = ST_LOAD;
      default: state_d = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Session bookkeeping and the registered write port
  always_ff @(posedge clk) begin
    if (reset) begin
      word_count_q <= 7'd0;
      ptr_q        <= 32'h0;
      err_q        <= 1'b0;
      ovf_q        <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= 32'h0;
      wdata_q      <= 32'h0;
    end else begin
      we_q <= 1'b0;
      if (session_start) begin
        word_count_q <= 7'd0;
        ptr_q        <= BASE_ADDR;
        err_q        <= 1'b0;
        ovf_q        <= 1'b0;
      end else if (accept) begin
        if (enc_illegal) begin
          err_q <= 1'b1;
        end else begin
          we_q         <= 1'b1;
          addr_q       <= ptr_q;
          wdata_q      <= enc_word;
          ptr_q        <= ptr_q + 32'd4;
          word_count_q <= word_count_q + 7'd1;
        end
      end else if (mem_full) begin
        // Reached only when the final slot was filled without req_last
        ovf_q <= 1'b1;
      end
    end
  end

  assign imem_we    = we_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign busy       = (state_q == ST_LOAD);
  assign done       = (state_q == ST_DONE);
  assign err        = err_q;
  assign ovf        = ovf_q;
  assign word_count = word_count_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: scoreboard of expected {addr, word} per accepted request.
// Small memory depth so the overflow and exact-fill boundaries are reachable.
// Inputs driven #1 after rising edge; outputs sampled #1 after rising edge or on the falling edge.
module tb_instr_encoder;

  localparam int          DEPTH = 4;
  localparam logic [31:0] BASE  = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset, start, req_valid, req_ready, req_last;
  logic [3:0]  req_sel, req_cond, req_rn, req_rd, req_rm;
  logic [11:0] req_imm;
  logic        imem_we, busy, done, err, ovf;
  logic [31:0] imem_addr, imem_wdata;
  logic [6:0]  word_count;

  int n_cmp = 0;
  int n_bad = 0;
  int n_wr  = 0;
  int cyc   = 0;
  int last_wr_cyc = 0;
  int prev_wr_cyc = 0;
  logic [31:0] exp_ptr;
  logic [63:0] sb_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  instr_encoder #(.IMEM_DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
    .clk(clk), .reset(reset), .start(start),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_sel(req_sel), .req_cond(req_cond), .req_rn(req_rn), .req_rd(req_rd),
    .req_rm(req_rm), .req_imm(req_imm), .req_last(req_last),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .busy(busy), .done(done), .err(err), .ovf(ovf), .word_count(word_count)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference encoding written out from the decoder's field table
  function automatic logic [31:0] ref_word(input logic [3:0] sel, cond, rn, rd, rm,
                                           input logic [11:0] imm);
    logic [4:0] sh;
    sh = imm[4:0];
    case (sel)
      4'd0: ref_word = {cond, 8'h08, rn, rd, 8'h00, rm};
      4'd1: ref_word = {cond, 8'h04, rn, rd, 8'h00, rm};
      4'd2: ref_word = {cond, 8'h00, rn, rd, 8'h00, rm};
      4'd3: ref_word = {cond, 8'h18, rn, rd, 8'h00, rm};
      4'd4: ref_word = {cond, 8'h15, rn, 4'h0, 8'h00, rm};
      4'd5: ref_word = {cond, 8'h26, 4'h0, rd, sh, 3'b000, rm};
      4'd6: ref_word = {cond, 8'h22, 4'h0, rd, sh, 3'b010, rm};
      4'd7: ref_word = {cond, 8'h59, rn, rd, imm};
      4'd8: ref_word = {cond, 8'h58, rn, rd, imm};
      default: ref_word = 32'h0;
    endcase
  endfunction

  // Write monitor: every strobe must match the oldest expected write
  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      logic [63:0] e;
      n_wr++;
      prev_wr_cyc = last_wr_cyc;
      last_wr_cyc = cyc;
      if (sb_q.size() == 0) begin
        chk("unexpected_write", imem_addr, 32'hFFFF_FFFF);
      end else begin
        e = sb_q.pop_front();
        chk("imem_addr", imem_addr, e[63:32]);
        chk("imem_wdata", imem_wdata, e[31:0]);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
    exp_ptr = BASE;
  endtask

  task automatic send(input logic [3:0] sel, cond, rn, rd, rm, input logic [11:0] imm,
                      input logic last);
    int waited = 0;
    req_sel = sel; req_cond = cond; req_rn = rn; req_rd = rd; req_rm = rm;
    req_imm = imm; req_last = last; req_valid = 1'b1;
    while (req_ready !== 1'b1 && waited < 50) begin
      tick(1);
      waited++;
    end
    if (waited >= 50) begin
      chk("ready_timeout", {31'h0, req_ready}, 32'h1);
      req_valid = 1'b0;
      return;
    end
    if (sel <= 4'd8) begin
      sb_q.push_back({exp_ptr, ref_word(sel, cond, rn, rd, rm, imm)});
      exp_ptr = exp_ptr + 32'd4;
    end
    tick(1);
    req_valid = 1'b0;
    req_last  = 1'b0;
  endtask

  task automatic chk_all_zero(input string pfx);
    chk({pfx, "_we"}, {31'h0, imem_we}, 32'h0);
    chk({pfx, "_addr"}, imem_addr, 32'h0);
    chk({pfx, "_wdata"}, imem_wdata, 32'h0);
    chk({pfx, "_ready"}, {31'h0, req_ready}, 32'h0);
    chk({pfx, "_busy"}, {31'h0, busy}, 32'h0);
    chk({pfx, "_done"}, {31'h0, done}, 32'h0);
    chk({pfx, "_err"}, {31'h0, err}, 32'h0);
    chk({pfx, "_ovf"}, {31'h0, ovf}, 32'h0);
    chk({pfx, "_count"}, {25'h0, word_count}, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int wr0, acc;
    bit seen_drop;
    reset = 1'b1; start = 1'b0; req_valid = 1'b0; req_last = 1'b0;
    req_sel = 4'd0; req_cond = 4'd0; req_rn = 4'd0; req_rd = 4'd0; req_rm = 4'd0;
    req_imm = 12'd0; exp_ptr = BASE;
    tick(3);
    reset = 1'b0;
    tick(1);
    chk_all_zero("reset");

    // Single ADD ending the program
    do_start();
    chk("load_busy", {31'h0, busy}, 32'h1);
    chk("load_ready", {31'h0, req_ready}, 32'h1);
    send(4'd0, 4'hE, 4'd2, 4'd1, 4'd3, 12'h000, 1'b1);
    tick(2);
    chk("add_done", {31'h0, done}, 32'h1);
    chk("add_count", {25'h0, word_count}, 32'd1);

    // Back-to-back SUB then CMP (last); start from DONE
    do_start();
    send(4'd1, 4'hE, 4'd1, 4'd3, 4'd2, 12'h000, 1'b0);
    send(4'd4, 4'hE, 4'd1, 4'd7, 4'd2, 12'h000, 1'b1);
    tick(2);
    chk("b2b_gap", last_wr_cyc - prev_wr_cyc, 32'd1);
    chk("b2b_done", {31'h0, done}, 32'h1);
    chk("b2b_count", {25'h0, word_count}, 32'd2);
    chk("b2b_busy", {31'h0, busy}, 32'h0);

    // Memory ops, shift, and exact fill with last on the final slot
    do_start();
    send(4'd7, 4'hE, 4'd0, 4'd4, 4'd0, 12'h008, 1'b0);
    send(4'd8, 4'hE, 4'd0, 4'd4, 4'd0, 12'h008, 1'b0);
    send(4'd5, 4'hE, 4'd9, 4'd5, 4'd6, 12'h003, 1'b0);
    send(4'd3, 4'h1, 4'd7, 4'd8, 4'd9, 12'h000, 1'b1);
    tick(2);
    chk("fill_done", {31'h0, done}, 32'h1);
    chk("fill_ovf", {31'h0, ovf}, 32'h0);
    chk("fill_count", {25'h0, word_count}, 32'd4);

    // Illegal select between two ADDs
    do_start();
    send(4'd0, 4'hE, 4'd2, 4'd1, 4'd3, 12'h000, 1'b0);
    send(4'd12, 4'hE, 4'd2, 4'd1, 4'd3, 12'h000, 1'b0);
    send(4'd0, 4'hA, 4'd5, 4'd6, 4'd7, 12'h000, 1'b1);
    tick(2);
    chk("ill_err", {31'h0, err}, 32'h1);
    chk("ill_count", {25'h0, word_count}, 32'd2);
    do_start();
    chk("ill_err_clr", {31'h0, err}, 32'h0);
    // Illegal select carrying last still ends the session
    send(4'd15, 4'hE, 4'd0, 4'd0, 4'd0, 12'h000, 1'b1);
    tick(1);
    chk("ill_last_done", {31'h0, done}, 32'h1);
    chk("ill_last_count", {25'h0, word_count}, 32'd0);

    // Overflow: offer 6 requests without last; only DEPTH may land
    do_start();
    wr0 = n_wr; acc = 0; seen_drop = 1'b0;
    req_valid = 1'b1; req_last = 1'b0;
    for (int c = 0; c < 12 && acc < 6; c++) begin
      req_sel = (c % 2 == 0) ? 4'd2 : 4'd6;
      req_cond = 4'hE; req_rn = 4'(c); req_rd = 4'(c + 1); req_rm = 4'(c + 2);
      req_imm = 12'(c + 1);
      if (acc == DEPTH && !seen_drop) begin
        chk("ovf_ready_drop", {31'h0, req_ready}, 32'h0);
        seen_drop = 1'b1;
      end
      if (req_ready === 1'b1) begin
        sb_q.push_back({exp_ptr, ref_word(req_sel, req_cond, req_rn, req_rd, req_rm, req_imm)});
        exp_ptr = exp_ptr + 32'd4;
        acc++;
      end
      tick(1);
    end
    req_valid = 1'b0;
    tick(2);
    chk("ovf_accepts", acc, DEPTH);
    chk("ovf_writes", n_wr - wr0, DEPTH);
    chk("ovf_flag", {31'h0, ovf}, 32'h1);
    chk("ovf_done", {31'h0, done}, 32'h1);
    chk("ovf_count", {25'h0, word_count}, 32'd4);

    // Reset mid-stream after two writes
    do_start();
    send(4'd0, 4'hE, 4'd1, 4'd2, 4'd3, 12'h000, 1'b0);
    send(4'd2, 4'hE, 4'd4, 4'd5, 4'd6, 12'h000, 1'b0);
    tick(1);
    wr0 = n_wr;
    req_sel = 4'd6; req_cond = 4'hE; req_rn = 4'd1; req_rd = 4'd2; req_rm = 4'd3;
    req_imm = 12'h004; req_valid = 1'b1; reset = 1'b1;
    tick(1);
    reset = 1'b0; req_valid = 1'b0;
    chk_all_zero("midrst");
    tick(3);
    chk("midrst_no_wr", n_wr - wr0, 32'd0);
    do_start();
    send(4'd6, 4'hE, 4'd1, 4'd2, 4'd3, 12'h004, 1'b1);
    tick(2);
    chk("restart_done", {31'h0, done}, 32'h1);
    chk("sb_empty", sb_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
